// File: rtl/cdb_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : cdb_arbiter_pkg                                             |
// | Brief   : Shared types and constants for the CDB completion arbiter.  |
// |           Requester index order is load, mult, alu, branch (LSB 1st). |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package cdb_arbiter_pkg;

  localparam int CDB_SLOTS    = 2;
  localparam int NUM_FU_TOTAL = 4;

  // Requester index base for each functional-unit class
  localparam int LOAD_BASE    = 0;
  localparam int MULT_BASE    = 1;
  localparam int ALU_BASE     = 2;
  localparam int BRANCH_BASE  = 3;

  typedef logic [CDB_SLOTS-1:0][NUM_FU_TOTAL-1:0] CDB_GNT_BUS;
  typedef logic [$clog2(NUM_FU_TOTAL)-1:0]         RR_PTR;

  // Number of set bits in a request-sized vector (zero-extended to 32)
  function automatic int unsigned popcount32(input logic [31:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < 32; i++) begin
      c = c + {31'b0, v[i]};
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cdb_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : cdb_arbiter_if                                              |
// | Brief   : Request/grant bundle between functional units and the CDB   |
// |           arbiter. master = requester side, slave = arbiter side.     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int N       = CDB_SLOTS,
  parameter int NUM_REQ = NUM_FU_TOTAL
);
  localparam int CW = $clog2(N + 1);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        urgent;
  logic [N-1:0][NUM_REQ-1:0] gnt_bus;
  logic [NUM_REQ-1:0]        gnt;
  logic [CW-1:0]             slots_used;
  logic                      urgent_overflow;

  modport master (output req, urgent,
                  input  gnt_bus, gnt, slots_used, urgent_overflow);
  modport slave  (input  req, urgent,
                  output gnt_bus, gnt, slots_used, urgent_overflow);
endinterface
`default_nettype wire

// File: rtl/cdb_rr_select.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : cdb_rr_select                                               |
// | Brief   : Combinational picker. Walks the candidate mask from `start` |
// |           upward with wrap and returns up to `free_slots` one-hot     |
// |           picks in walk order, plus the last index picked.            |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module cdb_rr_select #(
  parameter int N       = 2,
  parameter int NUM_REQ = 4,
  parameter int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  parameter int CW      = $clog2(N + 1)
) (
  input  wire [NUM_REQ-1:0]        cand,
  input  wire [PW-1:0]             start,
  input  wire [CW-1:0]             free_slots,
  output logic [N-1:0][NUM_REQ-1:0] picks,
  output logic [NUM_REQ-1:0]       pick_mask,
  output logic [CW-1:0]            num_picks,
  output logic [PW-1:0]            last_idx,
  output logic                     any_pick
);

  int w_cnt;
  int w_idx;

  // Rotated scan: each hit fills the next free output slot
  always_comb begin
    picks     = '0;
    pick_mask = '0;
    last_idx  = '0;
    any_pick  = 1'b0;
    w_cnt     = 0;
    w_idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = (int'(start) + k) % NUM_REQ;
      if (cand[w_idx] && (w_cnt < int'(free_slots)) && (w_cnt < N)) begin
        picks[w_cnt][w_idx] = 1'b1;
        pick_mask[w_idx]    = 1'b1;
        last_idx            = PW'(w_idx);
        any_pick            = 1'b1;
        w_cnt               = w_cnt + 1;
      end
    end
    num_picks = CW'(w_cnt);
  end

endmodule
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : cdb_arbiter                                                 |
// | Brief   : Completion-bus arbiter. Urgent single-cycle units win       |
// |           first, then starved requesters, then rotating priority.     |
// |           Optional aging enabled by defining CDB_ARB_STARVE_EN.       |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N            = CDB_SLOTS,
  parameter int NUM_REQ      = NUM_FU_TOTAL,
  parameter int WAIT_W       = 4,
  parameter int STARVE_LIMIT = 8
) (
  input wire           clock,
  input wire           reset,
  cdb_arbiter_if.slave bus
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] C_SLOTS = CW'(N);

  logic [PW-1:0]             r_rr_ptr;
  logic                      r_urgent_overflow;

  logic [NUM_REQ-1:0]        w_urg_cand;
  logic [NUM_REQ-1:0]        w_starve_cand;
  logic [NUM_REQ-1:0]        w_rr_cand;
  logic [N-1:0][NUM_REQ-1:0] w_u_picks, w_s_picks, w_r_picks;
  logic [NUM_REQ-1:0]        w_s_mask;
  logic [NUM_REQ-1:0]        w_unused_u_mask, w_unused_r_mask;
  logic [CW-1:0]             w_u_cnt, w_s_cnt, w_r_cnt;
  logic [CW-1:0]             w_free_s, w_free_r;
  logic [PW-1:0]             w_r_last;
  logic [PW-1:0]             w_unused_u_last, w_unused_s_last;
  logic                      w_r_any, w_unused_u_any, w_unused_s_any;
  logic [N-1:0][NUM_REQ-1:0] w_bus;
  logic [NUM_REQ-1:0]        w_gnt;

  // Urgent bits only count when backed by a request
  assign w_urg_cand = bus.req & bus.urgent;

`ifdef CDB_ARB_STARVE_EN
  logic [NUM_REQ-1:0][WAIT_W-1:0] r_wait_cnt;

  // Non-urgent requesters that have waited long enough are promoted
  always_comb begin
    w_starve_cand = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_starve_cand[i] = bus.req[i] && !bus.urgent[i] &&
                         (32'(r_wait_cnt[i]) >= 32'(STARVE_LIMIT));
    end
  end

  // Per-requester aging: count while denied (saturating), clear otherwise
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wait_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.req[i] && !w_gnt[i]) begin
          if (r_wait_cnt[i] != '1) begin
            r_wait_cnt[i] <= r_wait_cnt[i] + WAIT_W'(1);
          end
        end else begin
          r_wait_cnt[i] <= '0;
        end
      end
    end
  end
`else
  assign w_starve_cand = '0;
`endif

  // Starved requesters already placed must not be picked twice by the rotor
  assign w_rr_cand = bus.req & ~bus.urgent & ~w_s_mask;
  assign w_free_s  = C_SLOTS - w_u_cnt;
  assign w_free_r  = w_free_s - w_s_cnt;

  cdb_rr_select #(.N(N), .NUM_REQ(NUM_REQ), .PW(PW), .CW(CW)) u_sel_urgent (
    .cand(w_urg_cand), .start('0), .free_slots(C_SLOTS),
    .picks(w_u_picks), .pick_mask(w_unused_u_mask), .num_picks(w_u_cnt),
    .last_idx(w_unused_u_last), .any_pick(w_unused_u_any)
  );

  cdb_rr_select #(.N(N), .NUM_REQ(NUM_REQ), .PW(PW), .CW(CW)) u_sel_starve (
    .cand(w_starve_cand), .start('0), .free_slots(w_free_s),
    .picks(w_s_picks), .pick_mask(w_s_mask), .num_picks(w_s_cnt),
    .last_idx(w_unused_s_last), .any_pick(w_unused_s_any)
  );

  cdb_rr_select #(.N(N), .NUM_REQ(NUM_REQ), .PW(PW), .CW(CW)) u_sel_rr (
    .cand(w_rr_cand), .start(r_rr_ptr), .free_slots(w_free_r),
    .picks(w_r_picks), .pick_mask(w_unused_r_mask), .num_picks(w_r_cnt),
    .last_idx(w_r_last), .any_pick(w_r_any)
  );

  // Pack the three priority classes into contiguous slots, urgent first
  always_comb begin
    w_bus = '0;
    w_gnt = '0;
    for (int s = 0; s < N; s++) begin
      if (s < int'(w_u_cnt)) begin
        w_bus[s] = w_u_picks[s];
      end else if (s < int'(w_u_cnt) + int'(w_s_cnt)) begin
        w_bus[s] = w_s_picks[s - int'(w_u_cnt)];
      end else if (s < int'(w_u_cnt) + int'(w_s_cnt) + int'(w_r_cnt)) begin
        w_bus[s] = w_r_picks[s - int'(w_u_cnt) - int'(w_s_cnt)];
      end
      w_gnt = w_gnt | w_bus[s];
    end
  end

  assign bus.gnt_bus         = reset ? '0 : w_bus;
  assign bus.gnt             = reset ? '0 : w_gnt;
  assign bus.slots_used      = reset ? '0 : (w_u_cnt + w_s_cnt + w_r_cnt);
  assign bus.urgent_overflow = r_urgent_overflow;

  // Rotor advances past the last round-robin winner only
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rr_ptr <= '0;
    end else if (w_r_any) begin
      r_rr_ptr <= (w_r_last == PW'(NUM_REQ - 1)) ? '0 : (w_r_last + PW'(1));
    end
  end

  // Sticky flag: more urgent requesters than slots in some cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      r_urgent_overflow <= 1'b0;
    end else if (popcount32(32'(w_urg_cand)) > 32'(N)) begin
      r_urgent_overflow <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_cdb_arbiter                                              |
// | Brief   : Self-checking bench for cdb_arbiter (N=2, NUM_REQ=8,        |
// |           STARVE_LIMIT=3). Honors CDB_ARB_STARVE_EN like the design.  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_cdb_arbiter;

  localparam int N  = 2;
  localparam int NR = 8;
  localparam int WW = 4;
  localparam int SL = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  cdb_arbiter_if #(.N(N), .NUM_REQ(NR)) bus_if ();

  cdb_arbiter #(.N(N), .NUM_REQ(NR), .WAIT_W(WW), .STARVE_LIMIT(SL)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus_if)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  int                 m_ptr = 0;
  int                 m_wait [NR];
  bit                 m_ovf = 1'b0;
  bit                 m_rst = 1'b0;
  logic [NR-1:0]      m_req = '0;
  logic [NR-1:0]      m_urg = '0;
  int                 m_rr_last = 0;
  bit                 m_rr_hit = 1'b0;
  logic [N-1:0][NR-1:0] exp_bus;
  logic [NR-1:0]      exp_gnt;
  int                 exp_used;
  logic               exp_ovf;

  // Drive one cycle of inputs and compute the expected allocation
  task automatic apply(input bit rst_v, input logic [NR-1:0] r, input logic [NR-1:0] u);
    int i;
    @(negedge clock);
    reset = rst_v;
    bus_if.req = r;
    bus_if.urgent = u;
    m_rst = rst_v; m_req = r; m_urg = u;
    exp_bus = '0; exp_gnt = '0; exp_used = 0; m_rr_hit = 1'b0;
    for (int k = 0; k < NR; k++) begin
      if (r[k] && u[k] && exp_used < N) begin
        exp_bus[exp_used][k] = 1'b1; exp_gnt[k] = 1'b1; exp_used++;
      end
    end
`ifdef CDB_ARB_STARVE_EN
    for (int k = 0; k < NR; k++) begin
      if (r[k] && !u[k] && m_wait[k] >= SL && exp_used < N) begin
        exp_bus[exp_used][k] = 1'b1; exp_gnt[k] = 1'b1; exp_used++;
      end
    end
`endif
    for (int k = 0; k < NR; k++) begin
      i = (m_ptr + k) % NR;
      if (r[i] && !u[i] && !exp_gnt[i] && exp_used < N) begin
        exp_bus[exp_used][i] = 1'b1; exp_gnt[i] = 1'b1; exp_used++;
        m_rr_last = i; m_rr_hit = 1'b1;
      end
    end
    if (rst_v) begin
      exp_bus = '0; exp_gnt = '0; exp_used = 0;
    end
    exp_ovf = m_ovf;
    #2;
  endtask

  // Clock edge: update the model state from the cycle just checked
  task automatic advance();
    @(posedge clock);
    if (m_rst) begin
      m_ptr = 0; m_ovf = 1'b0;
      for (int k = 0; k < NR; k++) m_wait[k] = 0;
    end else begin
      if (m_rr_hit) m_ptr = (m_rr_last + 1) % NR;
      for (int k = 0; k < NR; k++) begin
        if (m_req[k] && !exp_gnt[k]) m_wait[k] = (m_wait[k] < (1 << WW) - 1) ? m_wait[k] + 1 : m_wait[k];
        else m_wait[k] = 0;
      end
      if ($countones(m_req & m_urg) > N) m_ovf = 1'b1;
    end
  endtask

  task automatic do_reset();
    apply(1'b1, '0, '0);
    advance();
  endtask

  task automatic test_reset();
    apply(1'b1, 8'hFF, 8'hFF);
    total++; if (bus_if.gnt_bus !== '0) begin bad++; $display("FAIL reset_gnt_bus got=%h exp=0", bus_if.gnt_bus); end
    total++; if (bus_if.slots_used !== 2'd0) begin bad++; $display("FAIL reset_slots got=%0d exp=0", bus_if.slots_used); end
    total++; if (bus_if.gnt !== 8'h00) begin bad++; $display("FAIL reset_gnt got=%h exp=00", bus_if.gnt); end
    advance();
    // Move the pointer off zero, then reset and confirm scanning restarts at 0
    apply(1'b0, 8'h01, 8'h00);
    advance();
    do_reset();
    apply(1'b0, 8'h81, 8'h00);
    total++; if (bus_if.urgent_overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", bus_if.urgent_overflow); end
    total++; if (bus_if.gnt_bus[0] !== 8'h01 || bus_if.gnt_bus[1] !== 8'h80) begin
      bad++; $display("FAIL reset_ptr got=%h exp=8001", bus_if.gnt_bus); end
    advance();
  endtask

  task automatic test_urgent();
    do_reset();
    apply(1'b0, 8'hFF, 8'h30);
    total++; if (bus_if.gnt_bus[0] !== 8'h10 || bus_if.gnt_bus[1] !== 8'h20) begin
      bad++; $display("FAIL urgent_slots got=%h exp=2010", bus_if.gnt_bus); end
    total++; if (bus_if.gnt !== 8'h30) begin bad++; $display("FAIL urgent_gnt got=%h exp=30", bus_if.gnt); end
    advance();
    apply(1'b0, 8'h0F, 8'h00);
    total++; if (bus_if.gnt !== 8'h03) begin bad++; $display("FAIL urgent_ptr_held got=%h exp=03", bus_if.gnt); end
    advance();
  endtask

  task automatic test_rr_wrap();
    logic [NR-1:0] want [3];
    want[0] = 8'h03; want[1] = 8'h0C; want[2] = 8'h03;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      apply(1'b0, 8'h0F, 8'h00);
      total++; if (bus_if.gnt !== want[c] || bus_if.gnt_bus !== exp_bus) begin
        bad++; $display("FAIL rr_wrap[%0d] got=%h/%h exp=%h/%h", c, bus_if.gnt, bus_if.gnt_bus, want[c], exp_bus); end
      total++; if (bus_if.slots_used !== 2'd2) begin bad++; $display("FAIL rr_wrap_slots[%0d] got=%0d exp=2", c, bus_if.slots_used); end
      advance();
    end
  endtask

  task automatic test_starve();
    logic [NR-1:0] want_slot1;
`ifdef CDB_ARB_STARVE_EN
    want_slot1 = 8'h01;
`else
    want_slot1 = 8'h02;
`endif
    do_reset();
    apply(1'b0, 8'h01, 8'h00);
    advance();
    for (int c = 0; c < 3; c++) begin
      apply(1'b0, 8'hC1, 8'hC0);
      total++; if (bus_if.gnt !== 8'hC0) begin bad++; $display("FAIL starve_hold[%0d] got=%h exp=C0", c, bus_if.gnt); end
      advance();
    end
    apply(1'b0, 8'h43, 8'h40);
    total++; if (bus_if.gnt_bus[1] !== want_slot1 || bus_if.gnt_bus !== exp_bus) begin
      bad++; $display("FAIL starve_slot1 got=%h exp=%h", bus_if.gnt_bus, exp_bus); end
    advance();
    apply(1'b0, 8'h0E, 8'h00);
    total++; if (bus_if.gnt !== exp_gnt) begin bad++; $display("FAIL starve_ptr got=%h exp=%h", bus_if.gnt, exp_gnt); end
    advance();
  endtask

  task automatic test_overflow();
    do_reset();
    apply(1'b0, 8'h07, 8'h07);
    total++; if (bus_if.gnt !== 8'h03) begin bad++; $display("FAIL ovf_gnt got=%h exp=03", bus_if.gnt); end
    total++; if (bus_if.urgent_overflow !== 1'b0) begin bad++; $display("FAIL ovf_early got=%b exp=0", bus_if.urgent_overflow); end
    advance();
    for (int c = 0; c < 2; c++) begin
      apply(1'b0, 8'h00, 8'h00);
      total++; if (bus_if.urgent_overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky[%0d] got=%b exp=1", c, bus_if.urgent_overflow); end
      total++; if (bus_if.gnt !== 8'h00 || bus_if.slots_used !== 2'd0) begin
        bad++; $display("FAIL ovf_idle[%0d] got=%h/%0d exp=00/0", c, bus_if.gnt, bus_if.slots_used); end
      advance();
    end
    do_reset();
    apply(1'b0, 8'h00, 8'h00);
    total++; if (bus_if.urgent_overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", bus_if.urgent_overflow); end
    advance();
  endtask

  task automatic test_reset_mid_aging();
    do_reset();
    apply(1'b0, 8'h01, 8'h00);
    advance();
    for (int c = 0; c < 2; c++) begin
      apply(1'b0, 8'h07, 8'h03);
      advance();
    end
    apply(1'b1, 8'h07, 8'h03);
    total++; if (bus_if.gnt !== 8'h00) begin bad++; $display("FAIL aging_rst_gnt got=%h exp=00", bus_if.gnt); end
    advance();
    // Stale aging would promote requester 2 here; a cleared count leaves it to the rotor
    apply(1'b0, 8'h07, 8'h03);
    advance();
    apply(1'b0, 8'h0E, 8'h08);
    total++; if (bus_if.gnt !== 8'h0A || bus_if.gnt_bus !== exp_bus) begin
      bad++; $display("FAIL aging_cleared got=%h exp=0A", bus_if.gnt); end
    advance();
  endtask

  task automatic test_random();
    logic [NR-1:0] r, u;
    bit rs;
    for (int c = 0; c < 400; c++) begin
      rs = ($urandom_range(0, 39) == 0);
      r  = NR'($urandom);
      u  = r & NR'($urandom) & NR'($urandom) & NR'($urandom);
      apply(rs, r, u);
      total++; if (bus_if.gnt_bus !== exp_bus || bus_if.gnt !== exp_gnt) begin
        bad++; $display("FAIL rand_grant[%0d] got=%h exp=%h req=%h urg=%h", c, bus_if.gnt_bus, exp_bus, r, u); end
      total++; if (bus_if.slots_used !== 2'(exp_used) || bus_if.urgent_overflow !== exp_ovf) begin
        bad++; $display("FAIL rand_status[%0d] got=%0d/%b exp=%0d/%b", c, bus_if.slots_used, bus_if.urgent_overflow, exp_used, exp_ovf); end
      advance();
    end
  endtask

  initial begin
    for (int k = 0; k < NR; k++) m_wait[k] = 0;
    bus_if.req = '0;
    bus_if.urgent = '0;
    test_reset();
    test_urgent();
    test_rr_wrap();
    test_starve();
    test_overflow();
    test_reset_mid_aging();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cdb_arbiter.md
# cdb_arbiter

Completion-bus arbiter for the execute stage. Each cycle it decides which functional units drive the `N` CDB slots, and produces the per-slot one-hot grant bus consumed by the execute-stage result mux. Single-cycle units (ALU, branch) hold results for one cycle only, so they are marked urgent and always win. Multi-cycle units (mult, load buffer) share the remaining slots through a rotating-priority pointer, with optional starvation aging.

## Interface
- `N`, default 2: number of CDB slots.
- `NUM_REQ`, default `NUM_FU_TOTAL`: number of requesters; index order is load, mult, alu, branch (LSB first).
- `WAIT_W`, default 4: width of the per-requester wait counters.
- `STARVE_LIMIT`, default 8: wait count at which a requester is promoted.
- `clock` input 1: clock.
- `reset` input 1: synchronous, active-high.
- `req` input `NUM_REQ`: requester holds a completed result.
- `urgent` input `NUM_REQ`: requester must be granted this cycle; a subset of `req`.
- `gnt_bus` output `N`×`NUM_REQ`: one-hot or zero per slot; slot i feeds `complete_gnt_bus[i]`.
- `gnt` output `NUM_REQ`: OR of `gnt_bus` slots; drives `mult_cdb_gnt` and `load_cdb_gnt`.
- `slots_used` output `$clog2(N+1)`: number of slots granted this cycle.
- `urgent_overflow` output 1: sticky error, set when popcount(`urgent`) > N.

## Operation
- Grants are combinational from `req`, `urgent` and registered state.
- Allocation order:
  1. Urgent requesters, lowest index first.
  2. Starved requesters (`CDB_ARB_STARVE_EN` only), lowest index first.
  3. Remaining non-urgent requests, searched from `rr_ptr` upward with wrap at `NUM_REQ-1` → 0.
- A requester receives at most one slot. Slots are filled in ascending slot index with no holes. Unused slots are all-zero.
- `rr_ptr` update on each edge: (index of the last requester granted in step 3 + 1) mod `NUM_REQ`. It is unchanged if step 3 granted nothing. Urgent and starved grants never move it.
- `wait_cnt[i]`:
  - increments, saturating at 2^WAIT_W−1, when `req[i]` && !`gnt[i]`;
  - clears when `gnt[i]` or !`req[i]`.
- Starved means `wait_cnt[i]` ≥ `STARVE_LIMIT`.
- Urgent overflow: grant the lowest N urgent requesters and set `urgent_overflow` on the next edge. It holds until reset.
- `urgent` bits without a matching `req` bit are ignored.
- `req` = 0: all grants are 0 and state is unchanged apart from counter clears.

## Timing
- Latency from `req` to `gnt` is 0 cycles (same cycle). State updates on the rising edge after the grant.
- A requester must hold `req` until it sees `gnt` high. De-asserting `req` early clears its counter.
- While `reset` is high, `gnt_bus`, `gnt` and `slots_used` are forced to 0 regardless of `req`.
- Register reset values: `rr_ptr` = 0, all `wait_cnt` = 0, `urgent_overflow` = 0.
- Reset asserted mid-operation discards all aging and the pointer position. The first cycle after reset arbitrates from index 0.

## Configuration
- `CDB_ARB_STARVE_EN` defined: wait counters and the starved priority class are present, and `WAIT_W`/`STARVE_LIMIT` are used.
- `CDB_ARB_STARVE_EN` undefined: no counters; allocation is urgent first, then round-robin only. The parameters are ignored.

## Structure
- Shared package holds:
  - the `CDB_GNT_BUS` typedef (`[N-1:0][NUM_REQ-1:0]` logic);
  - the `RR_PTR` typedef (`$clog2(NUM_REQ)` bits);
  - `NUM_FU_TOTAL` and the requester index base constants for each FU class.
- Sub-module `cdb_rr_select` (combinational): given a candidate mask, a start pointer and a free-slot count, returns up to that many one-hot picks in rotated order, plus the last picked index. It is instantiated once for step 3. Steps 1–2 reuse it with start pointer 0.

## Test plan
Use N=2, NUM_REQ=8, STARVE_LIMIT=3 for all scenarios.
- Reset priority: `reset`=1, `req`=0xFF, `urgent`=0xFF → `gnt_bus`=0, `slots_used`=0. After reset, `rr_ptr`=0.
- Urgent priority: `req`=0xFF, `urgent`=0x30 → slot0 grants 4, slot1 grants 5, `gnt`=0x30, `rr_ptr` stays 0.
- Round-robin wrap: `req`=0x0F, `urgent`=0 over three cycles → grants {0,1}, then {2,3}, then {0,1}. `rr_ptr` goes 2, 4, then 2.
- Starvation (macro on): `urgent`=0xC0, `req`=0xC1 for 3 cycles → `wait_cnt[0]`=3. Then `urgent`=0x40, `req`=0x43, `rr_ptr`=1 → slot1 grants requester 0 rather than 1, and `rr_ptr` is unchanged. With the macro off, the same stimulus grants requester 1.
- Overflow: `urgent`=`req`=0x07 → grants {0,1}, `urgent_overflow`=1 from the next cycle and still 1 after `req` returns to 0. It clears only on `reset`.
- Reset mid-aging: `wait_cnt[2]`=2 then a one-cycle reset → counters are 0 and `rr_ptr`=0 on the first post-reset cycle.
